// File: rtl/mb_rx_flit_deser.sv
// Mainband RX deserialiser: lane bits (1 UI/clk) -> bytes -> flits -> FWFT flit FIFO.
// Latency: flit visible on flit_valid_o/flit_data_o one cycle after the edge sampling its final UI7.
// Backpressure: flit_ready_i holds flits in the FIFO; a completed flit arriving while full and not popping is dropped (overflow_o).
//
// Ports:
//   clk, reset          single clock; synchronous active-low reset
//   lane_mode_i         0 = all lanes, 1 = lower half of lanes only (latched per flit)
//   valid_i, data_i     framing lane and one bit per data lane for the current UI
//   flit_valid_o/flit_ready_i/flit_data_o   head-of-FIFO flit handshake, byte b at [8b+7:8b]
//   fifo_level_o        occupied FIFO entries
//   overflow_o, framing_err_o, clear_err_i  sticky error flags and their clear
module mb_rx_flit_deser #(
  parameter int NUM_LANES  = 16,
  parameter int FLIT_BYTES = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          lane_mode_i,
  input  logic                          valid_i,
  input  logic [NUM_LANES-1:0]          data_i,
  output logic                          flit_valid_o,
  input  logic                          flit_ready_i,
  output logic [FLIT_BYTES*8-1:0]       flit_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          framing_err_o,
  input  logic                          clear_err_i
);

  localparam int BYTE_W = $clog2(FLIT_BYTES);
  localparam int FPTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = FPTR_W + 1;
  localparam int HALF   = NUM_LANES / 2;

  localparam logic [BYTE_W:0] L_FULL  = (BYTE_W+1)'(NUM_LANES);
  localparam logic [BYTE_W:0] L_HALF  = (BYTE_W+1)'(HALF);
  localparam logic [BYTE_W:0] L_FLIT  = (BYTE_W+1)'(FLIT_BYTES);
  localparam logic [LVL_W-1:0] L_DEPTH = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ON, OFF, RESYNC} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_ui, w_ui_nxt, w_ui_cur;
  logic                w_capture, w_grp_done, w_viol;

  logic [BYTE_W-1:0]   r_ptr;
  logic                r_mode, w_mode;
  logic [BYTE_W:0]     w_lanes, w_ptr_sum;
  logic                w_flit_done;

  logic [7:0]          r_flit [FLIT_BYTES];
  logic [7:0]          w_flit [FLIT_BYTES];
  logic [FLIT_BYTES*8-1:0] w_flit_packed;

  logic [FLIT_BYTES*8-1:0] r_mem [FIFO_DEPTH];
  logic [FPTR_W-1:0]   r_wptr, r_rptr;
  logic [LVL_W-1:0]    r_level;
  logic                w_full, w_pop, w_push_ok, w_ovf_set;
  logic                r_ovf, r_ferr;

  // Framing FSM. IDLE treats valid_i=1 as UI0 of a new group, so a group
  // ending at UI7 simply returns to IDLE and back-to-back groups fall out.
  always_comb begin
    w_state_nxt = r_state;
    w_ui_nxt    = r_ui;
    w_ui_cur    = r_ui;
    w_capture   = 1'b0;
    w_grp_done  = 1'b0;
    w_viol      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ui_cur = 3'd0;
        if (valid_i) begin
          w_capture   = 1'b1;
          w_ui_nxt    = 3'd1;
          w_state_nxt = ON;
        end
      end
      ON: begin
        if (valid_i) begin
          w_capture = 1'b1;
          w_ui_nxt  = r_ui + 3'd1;
          if (r_ui == 3'd3) w_state_nxt = OFF;
        end else begin
          w_viol      = 1'b1;
          w_state_nxt = RESYNC;
        end
      end
      OFF: begin
        if (!valid_i) begin
          w_capture = 1'b1;
          w_ui_nxt  = r_ui + 3'd1;
          if (r_ui == 3'd7) begin
            w_grp_done  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_viol      = 1'b1;
          w_state_nxt = RESYNC;
        end
      end
      RESYNC: begin
        // A high framing lane here is never a UI0; wait for it to drop.
        if (!valid_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Lane mode is taken only at UI0 of a flit's first group and held after.
  assign w_mode      = (r_state == IDLE && valid_i && r_ptr == '0) ? lane_mode_i : r_mode;
  assign w_lanes     = w_mode ? L_HALF : L_FULL;
  assign w_ptr_sum   = {1'b0, r_ptr} + w_lanes;
  assign w_flit_done = w_grp_done && (w_ptr_sum == L_FLIT);

  // Bits land directly in their flit byte; the combinational view includes
  // the current UI so the final UI7 can be pushed on the same edge.
  always_comb begin
    w_flit = r_flit;
    if (w_capture) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (i < HALF || !w_mode) w_flit[r_ptr + BYTE_W'(i)][w_ui_cur] = data_i[i];
      end
    end
  end

  always_comb begin
    w_flit_packed = '0;
    for (int b = 0; b < FLIT_BYTES; b++) w_flit_packed[8*b +: 8] = w_flit[b];
  end

  // FIFO control. A full FIFO can still accept when the head leaves this cycle.
  assign flit_valid_o = (r_level != '0);
  assign w_full       = (r_level == L_DEPTH);
  assign w_pop        = flit_valid_o & flit_ready_i;
  assign w_push_ok    = w_flit_done & (~w_full | w_pop);
  assign w_ovf_set    = w_flit_done & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ui    <= 3'd0;
      r_ptr   <= '0;
      r_mode  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ui    <= w_ui_nxt;
      r_mode  <= w_mode;
      if (w_viol) begin
        r_ptr <= '0;
      end else if (w_grp_done) begin
        r_ptr <= w_flit_done ? '0 : w_ptr_sum[BYTE_W-1:0];
      end
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop);
      // Set beats clear when both land on the same edge.
      r_ovf  <= w_ovf_set | (r_ovf  & ~clear_err_i);
      r_ferr <= w_viol    | (r_ferr & ~clear_err_i);
    end
  end

  // Datapath storage needs no reset: stale bytes are always overwritten
  // before a flit can complete, and empty FIFO data is masked below.
  always_ff @(posedge clk) begin
    for (int b = 0; b < FLIT_BYTES; b++) r_flit[b] <= w_flit[b];
    if (reset && w_push_ok) r_mem[r_wptr] <= w_flit_packed;
  end

  assign flit_data_o   = flit_valid_o ? r_mem[r_rptr] : '0;
  assign fifo_level_o  = r_level;
  assign overflow_o    = r_ovf;
  assign framing_err_o = r_ferr;

endmodule

// File: tb/tb_mb_rx_flit_deser.sv
// Directed bench for mb_rx_flit_deser with a flit scoreboard.
// Stimulus pushes expected flits; a negedge monitor pops and compares on every handshake.
// Control/flag expectations are checked inline one step after the relevant edge.
module tb_mb_rx_flit_deser;
  localparam int NL = 16;
  localparam int FB = 64;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              lane_mode_i;
  logic              valid_i;
  logic [NL-1:0]     data_i;
  logic              flit_valid_o;
  logic              flit_ready_i;
  logic [FB*8-1:0]   flit_data_o;
  logic [$clog2(FD):0] fifo_level_o;
  logic              overflow_o;
  logic              framing_err_o;
  logic              clear_err_i;

  always #5 clk = ~clk;

  mb_rx_flit_deser #(.NUM_LANES(NL), .FLIT_BYTES(FB), .FIFO_DEPTH(FD)) dut (
    .clk           (clk),
    .reset         (reset),
    .lane_mode_i   (lane_mode_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .flit_valid_o  (flit_valid_o),
    .flit_ready_i  (flit_ready_i),
    .flit_data_o   (flit_data_o),
    .fifo_level_o  (fifo_level_o),
    .overflow_o    (overflow_o),
    .framing_err_o (framing_err_o),
    .clear_err_i   (clear_err_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [FB*8-1:0] exp_q[$];
  int pop_cyc[$];
  bit track_lvl = 1'b0;
  int lvl_max = 0;
  logic [FB*8-1:0] mon_exp;
  logic [FB*8-1:0] F [5];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (track_lvl && int'(fifo_level_o) > lvl_max) lvl_max = int'(fifo_level_o);
      if (flit_valid_o && flit_ready_i) begin
        checks++;
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL flit_unexpected got=%h", flit_data_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (flit_data_o !== mon_exp) begin
            errors++;
            $display("FAIL flit_data got=%h exp=%h", flit_data_o, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, req);
    end
  endtask

  function automatic logic [FB*8-1:0] make_flit(input string s);
    logic [FB*8-1:0] f;
    byte c;
    f = '0;
    for (int b = 0; b < FB; b++) begin
      c = (b < s.len()) ? s[b] : 8'h20;
      f[8*b +: 8] = c;
    end
    return f;
  endfunction

  // Bits of UI u for group g: lane i carries bit u of byte g*lanes+i.
  function automatic logic [NL-1:0] lane_word(input logic [FB*8-1:0] f, input bit half,
                                              input int g, input int u);
    int lanes;
    logic [NL-1:0] w;
    lanes = half ? NL/2 : NL;
    for (int i = 0; i < NL; i++) begin
      if (i < lanes) w[i] = f[8*(g*lanes+i)+u];
      else           w[i] = 1'($urandom);
    end
    return w;
  endfunction

  task automatic drive_ui(input logic v, input logic [NL-1:0] d, input logic m);
    valid_i     = v;
    data_i      = d;
    lane_mode_i = m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_ui(1'b0, '0, 1'b0);
  endtask

  task automatic send_flit(input logic [FB*8-1:0] f, input bit half, input bit toggle,
                           input bit chk, input bit rdy_last);
    int lanes;
    int groups;
    bit m;
    lanes  = half ? NL/2 : NL;
    groups = FB / lanes;
    for (int g = 0; g < groups; g++) begin
      for (int u = 0; u < 8; u++) begin
        m = half;
        if (toggle && g > 0) m = ~half;
        if (g == groups-1 && u == 7) begin
          if (chk) check("valid_before_final_ui", int'(flit_valid_o), 0);
          if (rdy_last) flit_ready_i = 1'b1;
        end
        drive_ui(u < 4, lane_word(f, half, g, u), m);
      end
    end
    if (chk) check("valid_one_cycle_after_ui7", int'(flit_valid_o), 1);
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int n;
    n = 0;
    while ((fifo_level_o != '0 || exp_q.size() != 0) && n < maxc) begin
      idle(1);
      n++;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_level"}, int'(fifo_level_o), 0);
  endtask

  initial begin
    F[0] = make_flit("Hello, World! This is a test. Flit 0");
    F[1] = make_flit("This is Flit 1. It has more data");
    F[2] = make_flit("Flit 2. This is the last one.");
    F[3] = make_flit("Flit 3 fills the buffer");
    F[4] = make_flit("Flit 4 arrives when full");

    reset = 1'b0; lane_mode_i = 1'b0; valid_i = 1'b0; data_i = '0;
    flit_ready_i = 1'b0; clear_err_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(flit_valid_o), 0);
    check("rst_level", int'(fifo_level_o), 0);
    check("rst_ovf", int'(overflow_o), 0);
    check("rst_ferr", int'(framing_err_o), 0);
    reset = 1'b1;
    idle(2);

    // 1: full mode, three back-to-back flits, consumer always ready
    flit_ready_i = 1'b1;
    track_lvl = 1'b1;
    lvl_max = 0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(F[k]);
      send_flit(F[k], 1'b0, 1'b0, 1'b1, 1'b0);
    end
    idle(3);
    track_lvl = 1'b0;
    check("t1_level_max", lvl_max, 1);
    check("t1_pop_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("t1_gap01", pop_cyc[1] - pop_cyc[0], 32);
      check("t1_gap12", pop_cyc[2] - pop_cyc[1], 32);
    end

    // 2: half mode, upper lanes random, mode toggled after the first group
    exp_q.push_back(F[0]);
    send_flit(F[0], 1'b1, 1'b1, 1'b1, 1'b0);
    wait_drain("t2_drain", 20);

    // 3: consumer stalled, fifth flit overflows
    flit_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back(F[k]);
      send_flit(F[k], 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 3) begin
        check("t3_level_full", int'(fifo_level_o), 4);
        check("t3_ovf_before", int'(overflow_o), 0);
      end
    end
    check("t3_level_after_drop", int'(fifo_level_o), 4);
    check("t3_ovf_set", int'(overflow_o), 1);
    flit_ready_i = 1'b1;
    wait_drain("t3_drain", 20);

    // 4: framing violations and resync
    clear_err_i = 1'b1;
    idle(1);
    clear_err_i = 1'b0;
    check("t4_ovf_cleared", int'(overflow_o), 0);
    check("t4_ferr_clean", int'(framing_err_o), 0);
    for (int g = 0; g < 2; g++)
      for (int u = 0; u < 8; u++) drive_ui(u < 4, lane_word(F[0], 1'b0, g, u), 1'b0);
    drive_ui(1'b1, lane_word(F[0], 1'b0, 2, 0), 1'b0);
    drive_ui(1'b1, lane_word(F[0], 1'b0, 2, 1), 1'b0);
    check("t4_ferr_before_drop", int'(framing_err_o), 0);
    drive_ui(1'b0, lane_word(F[0], 1'b0, 2, 2), 1'b0);
    check("t4_ferr_set", int'(framing_err_o), 1);
    idle(1);
    // valid held high through UI4 and beyond: must stay in resync
    repeat (8) drive_ui(1'b1, NL'($urandom), 1'b0);
    idle(1);
    exp_q.push_back(F[1]);
    send_flit(F[1], 1'b0, 1'b0, 1'b1, 1'b0);
    wait_drain("t4_drain", 20);
    check("t4_ferr_sticky", int'(framing_err_o), 1);
    clear_err_i = 1'b1;
    idle(1);
    clear_err_i = 1'b0;
    check("t4_ferr_cleared", int'(framing_err_o), 0);

    // 5: reset mid-flit with a flit waiting in the FIFO
    flit_ready_i = 1'b0;
    send_flit(F[0], 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_level_before", int'(fifo_level_o), 1);
    for (int g = 0; g < 2; g++)
      for (int u = 0; u < 8; u++) drive_ui(u < 4, lane_word(F[2], 1'b0, g, u), 1'b0);
    reset = 1'b0;
    drive_ui(1'b1, lane_word(F[2], 1'b0, 2, 0), 1'b0);
    reset = 1'b1;
    check("t5_rst_valid", int'(flit_valid_o), 0);
    check("t5_rst_level", int'(fifo_level_o), 0);
    check("t5_rst_ovf", int'(overflow_o), 0);
    check("t5_rst_ferr", int'(framing_err_o), 0);
    flit_ready_i = 1'b1;
    exp_q.push_back(F[1]);
    send_flit(F[1], 1'b0, 1'b0, 1'b1, 1'b0);
    wait_drain("t5_drain", 20);

    // 6: full FIFO, pop coincides with a completing flit
    flit_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(F[k]);
      send_flit(F[k], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("t6_level_full", int'(fifo_level_o), 4);
    exp_q.push_back(F[4]);
    send_flit(F[4], 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_level_same", int'(fifo_level_o), 4);
    check("t6_no_ovf", int'(overflow_o), 0);
    wait_drain("t6_drain", 20);
    check("t6_ovf_end", int'(overflow_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mb_rx_flit_deser.md
Name: mb_rx_flit_deser

Overview:
Parametrised mainband receive deserialiser and flit buffer. It takes pre-sampled lane bits at one UI per clk cycle, with valid framing on a dedicated lane, and assembles bytes and then flits. Completed flits are stored in a FWFT FIFO and delivered over a valid/ready handshake. Compared with the existing MB_RX it adds lane-width modes, framing-error detection and resync, backpressure and overflow reporting. It sits between the mainband analog capture stage and the logical PHY flit consumer.

Parameters:
NUM_LANES, 16, number of data lanes; must be even.
FLIT_BYTES, 64, bytes per flit; must be a multiple of NUM_LANES.
FIFO_DEPTH, 4, flit buffer entries; power of 2, at least 2.

Ports:
clk  input  1  single clock; one UI sampled per rising edge.
reset  input  1  synchronous, active-low reset (asserted when 0).
lane_mode_i  input  1  0 = all NUM_LANES lanes active; 1 = half width, lanes [NUM_LANES/2-1:0] only.
valid_i  input  1  valid framing lane.
data_i  input  NUM_LANES  one bit per lane for the current UI.
flit_valid_o  output  1  FIFO non-empty.
flit_ready_i  input  1  consumer accepts the head flit.
flit_data_o  output  FLIT_BYTES*8  head flit; byte b at bits [8b+7:8b].
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  occupied entries.
overflow_o  output  1  sticky; a flit was dropped because the FIFO was full.
framing_err_o  output  1  sticky; a valid framing violation was seen.
clear_err_i  input  1  clears both sticky flags.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All outputs go to 0, the FIFO empties, the byte pointer goes to 0 and the FSM goes to IDLE.
  - Reset overrides every other input, including mid-flit.
- Byte group framing:
  - A group is 8 UIs, sent LSB first. valid_i is 1 for UI0–3 and 0 for UI4–7.
  - Lane i carries byte (ptr+i) of the flit.
- FSM states: IDLE, ON, OFF, RESYNC.
  - IDLE: valid_i=1 means this cycle is UI0; go to ON (UI counter=1). Gaps of any length between groups are allowed, and the partial flit is retained across them.
  - ON: UI1–3 require valid_i=1; after UI3 go to OFF.
  - OFF: UI4–7 require valid_i=0.
  - At UI7 the group completes and ptr advances by the active lane count (NUM_LANES or NUM_LANES/2). On the next cycle, valid_i=1 starts a new UI0 (back-to-back); otherwise the FSM returns to IDLE.
  - Violation in ON or OFF: set framing_err_o on the next edge, discard the current group and partial flit (ptr=0), and go to RESYNC.
  - RESYNC: stay until valid_i=0, then go to IDLE. A violating valid=1 cycle is never treated as UI0.
- Lane mode:
  - lane_mode_i is sampled at UI0 when ptr==0 and held for the whole flit.
  - Unused lanes are ignored in half mode.
  - A flit takes FLIT_BYTES/NUM_LANES groups in full mode and twice that in half mode.
- Flit completion:
  - The edge sampling UI7 of the final group writes the flit into the FIFO, and ptr wraps to 0.
  - flit_valid_o and flit_data_o are valid in the following cycle (1-cycle latency).
- FIFO:
  - FWFT; pop when flit_valid_o & flit_ready_i.
  - Push while full without a simultaneous pop: the flit is dropped, FIFO contents are unchanged, and overflow_o is set.
  - Push and pop in the same cycle while full: accepted, no overflow, level unchanged.
  - Push and pop in the same cycle while empty: the push is stored, and the pop is ignored because flit_valid_o was 0.
  - Read/write pointers wrap modulo FIFO_DEPTH. fifo_level_o ranges 0..FIFO_DEPTH.
- Sticky flags: clear_err_i clears them; if a set and a clear land on the same edge, the set wins.
- flit_data_o is don't-care when flit_valid_o=0; the bench must not check it then.

Test Plan:
1. Full mode, flit_ready_i=1, three back-to-back ASCII flits ("Hello, World! This is a test. Flit 0", "This is Flit 1. It has more data", "Flit 2. This is the last one.", space-padded) -> three pulses on flit_valid_o, 32 cycles apart, each 1 cycle after the final UI7; bytes match exactly; level never exceeds 1.
2. lane_mode_i=1, same flit 0 on lanes [7:0], lanes [15:8] driven with random data -> one flit after 8 groups (64 UIs), matches flit 0; a mode toggle mid-flit has no effect.
3. flit_ready_i=0, five flits sent -> fifo_level_o=4, overflow_o=1 after the fifth; then ready=1 pops flits 0–3 in order and the level returns to 0.
4. valid_i drops at UI2 of group 2 -> framing_err_o=1 next cycle and the partial flit is discarded. valid_i held high into OFF stays in RESYNC until valid_i=0. The next full flit is received correctly; clear_err_i=1 clears the flag.
5. reset=0 for one edge after 2 groups of a flit -> all outputs 0 and level 0; the following complete flit is received intact with no stale bytes.
6. FIFO full (4) with ready=1 on the same cycle as a flit completion -> overflow_o stays 0, level stays 4, and the new flit appears after the existing three.
